// File: rtl/fft_loader.sv
// fft_loader: windows real samples with a registered Hann LUT, writes them bit-reversed
// into the FFT RAM with N_2 bits of headroom, then pulses fft_start and waits for fft_done.
module fft_loader #(
   parameter int width = 16,
   parameter int N_2 = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [width-1:0]   sample_in,
   input  logic               sample_valid,
   output logic               sample_ready,
   output logic [N_2-1:0]     hann_idx,
   input  logic [width-1:0]   hann_coef,
   output logic               we,
   output logic [N_2-1:0]     wadr,
   output logic [2*width-1:0] wd,
   output logic               fft_start,
   input  logic               fft_done
);
   localparam int N = 1 << N_2;
   typedef enum logic {LOAD, WAIT_DONE} state_t;
   state_t state, state_nx;
   logic [N_2:0] k;
   logic accept, s1_v, s1_last, we_q, we_last, start_q;
   logic signed [width-1:0] s1_x;
   logic [N_2-1:0] s1_adr, wadr_q;
   logic [2*width-1:0] wd_q;
   logic signed [2*width:0] prod;
   logic signed [width-1:0] re;

   function automatic logic [N_2-1:0] bitrev(input logic [N_2-1:0] a);
      for (int i = 0; i < N_2; i++) bitrev[i] = a[N_2-1-i];
   endfunction

   always_ff @(posedge clk) state <= reset ? LOAD : state_nx;

   always_comb state_nx = (state == LOAD && we_q && we_last) ? WAIT_DONE :
                          (state == WAIT_DONE && fft_done) ? LOAD : state;

   // outputs are forced quiet while reset is held, even if a write was already registered
   always_comb begin
      sample_ready = state == LOAD && k < (N_2+1)'(N) && !reset;
      hann_idx = k[N_2-1:0];
      we = we_q && !reset;
      wadr = reset ? '0 : wadr_q;
      wd = reset ? '0 : wd_q;
      fft_start = start_q && !reset;
   end

   assign accept = sample_valid && sample_ready;
   assign prod = $signed(s1_x) * $signed({1'b0, hann_coef});
   assign re = width'((prod >>> width) >>> N_2);

   always_ff @(posedge clk) begin
      if (reset) begin
         k <= '0;
         s1_v <= 1'b0;
         s1_last <= 1'b0;
         s1_x <= '0;
         s1_adr <= '0;
         we_q <= 1'b0;
         we_last <= 1'b0;
         wadr_q <= '0;
         wd_q <= '0;
         start_q <= 1'b0;
      end else begin
         s1_v <= accept;
         s1_last <= accept && k == (N_2+1)'(N-1);
         if (accept) begin
            s1_x <= sample_in;
            s1_adr <= bitrev(k[N_2-1:0]);
         end
         we_q <= s1_v;
         we_last <= s1_v && s1_last;
         if (s1_v) begin
            wadr_q <= s1_adr;
            wd_q <= {re, {width{1'b0}}};
         end
         start_q <= we_q && we_last;
         k <= accept ? k + 1'b1 : (state == WAIT_DONE && fft_done) ? '0 : k;
      end
   end
endmodule

// File: tb/tb_fft_loader.sv
// tb_fft_loader: randomized frames against a frame-level model; writes and starts are
// queued with their due cycle and checked by an independent monitor.
module tb_fft_loader;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] sample_in = '0;
   logic sample_valid = 1'b0;
   logic sample_ready;
   logic [4:0] hann_idx;
   logic [15:0] hann_coef = '0;
   logic we;
   logic [4:0] wadr;
   logic [31:0] wd;
   logic fft_start;
   logic fft_done = 1'b0;

   fft_loader #(.width(16), .N_2(5)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .hann_idx(hann_idx), .hann_coef(hann_coef),
      .we(we), .wadr(wadr), .wd(wd), .fft_start(fft_start), .fft_done(fft_done)
   );

   typedef struct {int due; logic [4:0] adr; logic [31:0] wd;} wr_t;
   wr_t wq[$];
   int sq[$];
   logic [15:0] lut [32];
   int cyc = 0, checks = 0, passes = 0;
   int m_k = 0, wait_cyc = 1 << 30;
   logic ready_exp = 1'b0, idx_chk = 1'b0;
   logic [4:0] idx_exp = '0;
   wr_t e;
   int sd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) hann_coef <= lut[hann_idx];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      chk("sample_ready", {31'b0, sample_ready}, {31'b0, ready_exp});
      if (idx_chk) chk("hann_idx", {27'b0, hann_idx}, {27'b0, idx_exp});
      if (we) begin
         if (wq.size() == 0) chk("we_unexpected", {31'b0, we}, 32'd0);
         else begin
            e = wq.pop_front();
            chk("we_cycle", cyc, e.due);
            chk("wadr", {27'b0, wadr}, {27'b0, e.adr});
            chk("wd", wd, e.wd);
         end
      end else if (wq.size() > 0 && wq[0].due <= cyc) begin
         chk("we_missing", {31'b0, we}, 32'd1);
         void'(wq.pop_front());
      end
      if (fft_start) begin
         if (sq.size() == 0) chk("fft_start_unexpected", {31'b0, fft_start}, 32'd0);
         else begin
            sd = sq.pop_front();
            chk("fft_start_cycle", cyc, sd);
         end
      end else if (sq.size() > 0 && sq[0] <= cyc) begin
         chk("fft_start_missing", {31'b0, fft_start}, 32'd1);
         void'(sq.pop_front());
      end
      if (we && fft_start) chk("we_start_overlap", {31'b0, fft_start}, 32'd0);
   end

   // one cycle of stimulus; the model decides acceptance from frame position alone
   task automatic step(input logic v, input logic [15:0] s, input logic d, input logic r);
      longint ps, pc, p;
      logic [4:0] kk;
      wr_t w;
      sample_valid = v;
      sample_in = s;
      fft_done = d;
      reset = r;
      ready_exp = !r && m_k < 32;
      idx_chk = ready_exp;
      idx_exp = m_k[4:0];
      if (r) begin
         wq.delete();
         sq.delete();
         m_k = 0;
         wait_cyc = 1 << 30;
      end else if (v && ready_exp) begin
         ps = $signed(s);
         pc = lut[m_k];
         p = (ps * pc) >>> 21;
         kk = m_k[4:0];
         w.due = cyc + 2;
         w.adr = {<<{kk}};
         w.wd = {p[15:0], 16'h0000};
         wq.push_back(w);
         m_k++;
         if (m_k == 32) begin
            wait_cyc = cyc + 3;
            sq.push_back(cyc + 3);
         end
      end else if (d && m_k == 32 && cyc >= wait_cyc) m_k = 0;
      @(posedge clk);
      #1;
   endtask

   // mode 0: back-to-back, 1: every other cycle, 2: random valid with fft_done noise
   task automatic frame(input int mode, input logic directed, input int rst_after);
      logic v;
      logic [15:0] s;
      for (int n = 0; n < 500 && m_k < 32; n++) begin
         if (rst_after != 0 && m_k == rst_after) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b1);
            step(1'b0, 16'h0, 1'b0, 1'b1);
            return;
         end
         v = mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : ($urandom_range(0, 2) != 0);
         s = (directed && m_k == 0) ? 16'h4000 : (directed && m_k == 1) ? 16'h8000 : 16'($urandom);
         step(v, s, mode == 2 && $urandom_range(0, 4) == 0, 1'b0);
      end
      chk("frame_filled", m_k, 32);
      for (int i = 0; i < 40 && m_k == 32; i++)
         step($urandom_range(0, 1) == 1, 16'($urandom), i > 10 || $urandom_range(0, 1) == 1, 1'b0);
      chk("frame_restarted", m_k, 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) lut[i] = 16'($urandom);
      lut[0] = 16'h8000;
      lut[1] = 16'hFFFF;
      repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
      frame(0, 1'b1, 0);
      frame(1, 1'b0, 0);
      frame(2, 1'b0, 10);
      frame(0, 1'b0, 0);
      frame(2, 1'b0, 0);
      frame(2, 1'b1, 0);
      repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("write_queue_empty", wq.size(), 0);
      chk("start_queue_empty", sq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/fft_loader.md
FFT_LOADER -- requirements
Module: fft_loader

Interface
REQ-001 SHALL have parameter width, default 16, meaning the bit width of one real or imaginary component.
REQ-002 SHALL have parameter N_2, default 5, meaning log2 of the FFT point count N.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port sample_in, input, width bits: signed real time-domain sample.
REQ-006 SHALL have port sample_valid, input, 1 bit: sample_in holds a valid sample.
REQ-007 SHALL have port sample_ready, output, 1 bit: the loader accepts a sample this cycle.
REQ-008 SHALL have port hann_idx, output, N_2 bits: window LUT index; the LUT is registered and returns the value one cycle later.
REQ-009 SHALL have port hann_coef, input, width bits: unsigned Q0.width window coefficient for the previous cycle's hann_idx.
REQ-010 SHALL have port we, output, 1 bit: FFT RAM write enable.
REQ-011 SHALL have port wadr, output, N_2 bits: FFT RAM write address.
REQ-012 SHALL have port wd, output, 2*width bits: RAM write data, real part in the upper half, imaginary part in the lower half.
REQ-013 SHALL have port fft_start, output, 1 bit: one-cycle pulse that starts the transform.
REQ-014 SHALL have port fft_done, input, 1 bit: the transform has finished.

Function
REQ-015 SHALL have states LOAD and WAIT_DONE; LOAD holds a sample counter k, range 0..N-1.
REQ-016 sample_ready SHALL equal (state==LOAD && k<N && !reset); a sample is accepted in a cycle where sample_valid && sample_ready.
REQ-017 hann_idx SHALL equal k combinationally, so the index is presented in the cycle the sample is accepted.
REQ-018 On acceptance at cycle t, the sample and bitrev(k) SHALL be registered and k SHALL increment.
REQ-019 In cycle t+1, re SHALL be computed as ((signed sample x unsigned hann_coef) >>> width) >>> N_2, arithmetic shifts with truncation, giving N_2 bits of headroom; the imaginary part SHALL be 0.
REQ-020 In cycle t+2, registered we SHALL be 1, with wadr = bitrev(k) (bit-reversed k) and wd = {re[width-1:0], width'b0}.
REQ-021 we SHALL be high exactly once per accepted sample, and exactly N times per frame.
REQ-022 When valid is deasserted, the pipeline SHALL advance with no write; there SHALL be no backpressure beyond sample_ready.
REQ-023 After the N-th acceptance at cycle t, sample_ready SHALL be 0 from t+1; the last write SHALL occur at t+2; fft_start SHALL be 1 for exactly cycle t+3; state SHALL become WAIT_DONE.
REQ-024 In WAIT_DONE, we and sample_ready SHALL stay 0; fft_done high at cycle u SHALL move to LOAD with k=0, and sample_ready SHALL be 1 at u+1.
REQ-025 fft_done SHALL be ignored in LOAD; sample_valid SHALL be ignored when sample_ready=0.
REQ-026 fft_start SHALL never coincide with we=1.

Reset
REQ-027 While reset is high: state SHALL be LOAD, k=0, pipeline valids cleared, and we=0, wadr=0, wd=0, fft_start=0, sample_ready=0.
REQ-028 Reset mid-frame or mid-wait SHALL discard in-flight samples, with no write and no fft_start afterwards; the first post-reset sample SHALL be written to wadr 0.

Verification
REQ-029 Scalar path (width=16, N_2=5): sample 16'sh4000, coef 16'h8000 -> wd = 32'h0100_0000 two cycles after acceptance.
REQ-030 Negative rounding: sample 16'sh8000, coef 16'hFFFF -> wd upper half = 16'hFC00.
REQ-031 Address order: 32 back-to-back samples -> wadr sequence 0,16,8,24,4,...,31; hann_idx sequence 0..31.
REQ-032 Frame end: 32nd acceptance at t -> ready=0 at t+1, last we at t+2, single fft_start at t+3; fft_done at u -> ready=1 at u+1.
REQ-033 Gapped input: valid high every other cycle -> exactly 32 writes in bit-reversed order, then one fft_start.
REQ-034 Reset after 10 accepted samples -> no further we; the next frame's first sample is written to wadr 0.
